// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, state type, round count, FSM states
// and the GF(2^8) doubling helper used by MixColumns.
package aes_pkg;

  localparam int NR        = 10;
  localparam int SBOX_ROWS = 16;
  localparam int SBOX_COLS = 16;

  // AES state as [row][col] bytes; byte n of a FIPS block sits at [n%4][n/4].
  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } fsm_e;

  // Forward S-box, indexed [high nibble][low nibble].
  localparam logic [7:0] SBOX [SBOX_ROWS][SBOX_COLS] = '{
    '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76},
    '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0},
    '{8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15},
    '{8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75},
    '{8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84},
    '{8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf},
    '{8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8},
    '{8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2},
    '{8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73},
    '{8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb},
    '{8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79},
    '{8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08},
    '{8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a},
    '{8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e},
    '{8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf},
    '{8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16}
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_encryp_core_round.sv
// One full AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> (MixColumns unless final) -> AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
#(
  parameter int NO_SBOX_ROWS = 16,
  parameter int NO_SBOX_COLS = 16
) (
  input  state_t i_state,
  input  state_t i_key,
  input  logic   i_final,
  output state_t o_state
);

  logic [7:0] w_sbox [NO_SBOX_ROWS][NO_SBOX_COLS];
  state_t     w_sub;
  state_t     w_shift;
  state_t     w_mix;

  genvar gi, gj;

  // Local copy of the lookup table so each byte lane indexes its own view.
  for (gi = 0; gi < NO_SBOX_ROWS; gi++) begin : g_sbox_row
    for (gj = 0; gj < NO_SBOX_COLS; gj++) begin : g_sbox_col
      assign w_sbox[gi][gj] = SBOX[gi][gj];
    end
  end

  for (gi = 0; gi < 4; gi++) begin : g_row
    for (gj = 0; gj < 4; gj++) begin : g_col
      assign w_sub[gi][gj]   = w_sbox[i_state[gi][gj][7:4]][i_state[gi][gj][3:0]];
      // Row r rotates left by r positions.
      assign w_shift[gi][gj] = w_sub[gi][(gj + gi) % 4];
      // Row r of the MixColumns matrix is {2,3,1,1} rotated right by r.
      assign w_mix[gi][gj]   = xtime(w_shift[gi][gj])
                             ^ xtime(w_shift[(gi + 1) % 4][gj]) ^ w_shift[(gi + 1) % 4][gj]
                             ^ w_shift[(gi + 2) % 4][gj]
                             ^ w_shift[(gi + 3) % 4][gj];
    end
  end

  assign o_state = (i_final ? w_shift : w_mix) ^ i_key;

endmodule

// File: rtl/aes_encryp_core.sv
// Iterative AES-128 encryptor: one round per round key fetched over a
// request/valid handshake, with a one-cycle gap between key requests.
module aes_encryp_core
  import aes_pkg::*;
#(
  parameter int NO_ROWS      = 4,
  parameter int NO_COLS      = 4,
  parameter int NO_SBOX_ROWS = 16,
  parameter int NO_SBOX_COLS = 16
) (
  input  logic       aes_clk,
  input  logic       reset,
  input  logic       aes_core_en,
  input  logic       aes_encrypt_mode_en,
  input  logic [7:0] plain_text_i [NO_ROWS][NO_COLS],
  input  logic       plain_text_vld_i,
  output logic       core_rdy_o,
  output logic       key_req_o,
  output logic [3:0] key_sel_o,
  input  logic       key_vld_i,
  input  logic [7:0] cipher_key_i [4][4],
  output logic [7:0] cipher_text_o [NO_ROWS][NO_COLS],
  output logic       cipher_text_rdy_o
);

  fsm_e       r_state;
  fsm_e       w_state_next;
  state_t     r_data;
  state_t     w_data_next;
  state_t     r_ct;
  state_t     w_ct_next;
  logic [3:0] r_key_sel;
  logic [3:0] w_key_sel_next;
  logic       r_ct_rdy;
  logic       w_ct_rdy_next;

  state_t     w_pt;
  state_t     w_key;
  state_t     w_round_out;
  state_t     w_round_res;
  logic       w_start;
  logic       w_final;

  genvar gi, gj;

  for (gi = 0; gi < NO_ROWS; gi++) begin : g_io_row
    for (gj = 0; gj < NO_COLS; gj++) begin : g_io_col
      assign w_pt[gi][gj]          = plain_text_i[gi][gj];
      assign cipher_text_o[gi][gj] = r_ct[gi][gj];
    end
  end

  for (gi = 0; gi < 4; gi++) begin : g_key_row
    for (gj = 0; gj < 4; gj++) begin : g_key_col
      assign w_key[gi][gj] = cipher_key_i[gi][gj];
    end
  end

  assign w_start = plain_text_vld_i & aes_core_en & aes_encrypt_mode_en;
  assign w_final = (r_key_sel == 4'(NR));

  aes_enc_round #(
    .NO_SBOX_ROWS (NO_SBOX_ROWS),
    .NO_SBOX_COLS (NO_SBOX_COLS)
  ) u_round (
    .i_state (r_data),
    .i_key   (w_key),
    .i_final (w_final),
    .o_state (w_round_out)
  );

  // Round 0 is the initial key whitening only; later rounds use the full datapath.
  assign w_round_res = (r_key_sel == 4'd0) ? (r_data ^ w_key) : w_round_out;

  assign key_sel_o         = r_key_sel;
  assign cipher_text_rdy_o = r_ct_rdy;

  // Next-state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_ct_next      = r_ct;
    w_key_sel_next = r_key_sel;
    w_ct_rdy_next  = r_ct_rdy;
    core_rdy_o     = 1'b0;
    key_req_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        core_rdy_o = 1'b1;
        if (w_start) begin
          w_state_next   = ST_REQ;
          w_data_next    = w_pt;
          w_key_sel_next = 4'd0;
          w_ct_rdy_next  = 1'b0;
        end
      end
      ST_REQ: begin
        key_req_o = 1'b1;
        if (!aes_core_en) begin
          w_state_next = ST_IDLE;
        end else if (key_vld_i) begin
          w_data_next = w_round_res;
          if (w_final) begin
            w_ct_next     = w_round_res;
            w_ct_rdy_next = 1'b1;
            w_state_next  = ST_DONE;
          end else begin
            w_state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (!aes_core_en) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_REQ;
          // Saturate so the requested index never leaves 0..NR.
          if (r_key_sel < 4'(NR)) begin
            w_key_sel_next = r_key_sel + 4'd1;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Register bank with synchronous reset.
  always_ff @(posedge aes_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_ct      <= '0;
      r_key_sel <= 4'd0;
      r_ct_rdy  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_data    <= w_data_next;
      r_ct      <= w_ct_next;
      r_key_sel <= w_key_sel_next;
      r_ct_rdy  <= w_ct_rdy_next;
    end
  end

endmodule

// File: tb/tb_aes_encryp_core.sv
// Directed bench for aes_encryp_core using the FIPS-197 example vectors.
module tb_aes_encryp_core;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       aes_clk = 1'b0;
  logic       reset;
  logic       aes_core_en;
  logic       aes_encrypt_mode_en;
  logic [7:0] plain_text_i [4][4];
  logic       plain_text_vld_i;
  logic       core_rdy_o;
  logic       key_req_o;
  logic [3:0] key_sel_o;
  logic       key_vld_i;
  logic [7:0] cipher_key_i [4][4];
  logic [7:0] cipher_text_o [4][4];
  logic       cipher_text_rdy_o;

  int n_cmp;
  int n_fail;
  logic [127:0] rk_tab [2][11];

  aes_encryp_core dut (
    .aes_clk             (aes_clk),
    .reset               (reset),
    .aes_core_en         (aes_core_en),
    .aes_encrypt_mode_en (aes_encrypt_mode_en),
    .plain_text_i        (plain_text_i),
    .plain_text_vld_i    (plain_text_vld_i),
    .core_rdy_o          (core_rdy_o),
    .key_req_o           (key_req_o),
    .key_sel_o           (key_sel_o),
    .key_vld_i           (key_vld_i),
    .cipher_key_i        (cipher_key_i),
    .cipher_text_o       (cipher_text_o),
    .cipher_text_rdy_o   (cipher_text_rdy_o)
  );

  always #5 aes_clk = ~aes_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[x[7:4]][x[3:0]];
  endfunction

  function automatic logic [7:0] tb_xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS-197 key expansion producing the 11 round keys as 128-bit blocks.
  task automatic expand_key(input int kidx, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        t[31:24] = t[31:24] ^ rcon;
        rcon = tb_xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[kidx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic set_pt(input logic [127:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        plain_text_i[r][c] = v[127 - 8*(r + 4*c) -: 8];
  endtask

  task automatic set_key(input logic [127:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cipher_key_i[r][c] = v[127 - 8*(r + 4*c) -: 8];
  endtask

  function automatic logic [127:0] get_ct();
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[127 - 8*(r + 4*c) -: 8] = cipher_text_o[r][c];
    return v;
  endfunction

  // One encryption with an inline key responder. kill_kind: 0 none, 1 drop
  // aes_core_en, 2 assert reset, at the first REQ cycle of kill_round.
  // poke: issue a start while busy and drop the mode select mid-run.
  task automatic run_enc(input string tag, input logic [127:0] pt, input int kidx, input int lat,
                         input int kill_kind, input int kill_round, input int poke,
                         input logic [127:0] exp_ct);
    int cyc;
    int cnt;
    int rnd;
    bit finished;
    check({tag, "_rdy_before"}, 128'(core_rdy_o), 128'(1));
    set_pt(pt);
    plain_text_vld_i = 1'b1;
    tick();
    plain_text_vld_i = 1'b0;
    set_pt(~pt);
    check({tag, "_rdy_cleared"}, 128'(cipher_text_rdy_o), 128'(0));
    cyc = 1;
    cnt = 0;
    rnd = 0;
    finished = 1'b0;
    while (cyc <= 200 && !finished) begin
      if (cipher_text_rdy_o) begin
        finished = 1'b1;
      end else begin
        if (key_req_o) cnt++; else cnt = 0;
        if (key_req_o && cnt == 1) begin
          check({tag, "_key_sel"}, 128'(key_sel_o), 128'(rnd));
          if (kill_kind != 0 && rnd == kill_round) begin
            if (kill_kind == 1) aes_core_en = 1'b0; else reset = 1'b1;
            key_vld_i = 1'b0;
            tick();
            check({tag, "_kill_rdy"}, 128'(core_rdy_o), 128'(1));
            check({tag, "_kill_req"}, 128'(key_req_o), 128'(0));
            check({tag, "_kill_ctrdy"}, 128'(cipher_text_rdy_o), 128'(0));
            if (kill_kind == 2) begin
              check({tag, "_kill_sel"}, 128'(key_sel_o), 128'(0));
              check({tag, "_kill_ct"}, get_ct(), 128'(0));
            end
            reset = 1'b0;
            aes_core_en = 1'b1;
            tick();
            return;
          end
          rnd++;
        end
        plain_text_vld_i = (poke == 1 && rnd == 3 && cnt == 1);
        if (poke == 1 && rnd == 5) aes_encrypt_mode_en = 1'b0;
        key_vld_i = key_req_o && (cnt > lat);
        if (key_vld_i && rnd >= 1 && rnd <= 11) set_key(rk_tab[kidx][rnd-1]);
        else set_key(128'h0);
        tick();
        cyc++;
      end
    end
    key_vld_i = 1'b0;
    plain_text_vld_i = 1'b0;
    aes_encrypt_mode_en = 1'b1;
    check({tag, "_done_seen"}, 128'(finished), 128'(1));
    check({tag, "_done_cycle"}, 128'(cyc), 128'(22 + 11*lat));
    check({tag, "_rounds"}, 128'(rnd), 128'(11));
    check({tag, "_ct"}, get_ct(), exp_ct);
    tick();
    check({tag, "_idle_after"}, 128'(core_rdy_o), 128'(1));
    check({tag, "_rdy_held"}, 128'(cipher_text_rdy_o), 128'(1));
    check({tag, "_ct_held"}, get_ct(), exp_ct);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    aes_core_en = 1'b0;
    aes_encrypt_mode_en = 1'b0;
    plain_text_vld_i = 1'b0;
    key_vld_i = 1'b0;
    set_pt(128'h0);
    set_key(128'h0);
    expand_key(0, KEY_B);
    expand_key(1, KEY_C);
    tick();
    tick();
    check("rst_core_rdy", 128'(core_rdy_o), 128'(1));
    check("rst_key_req", 128'(key_req_o), 128'(0));
    check("rst_key_sel", 128'(key_sel_o), 128'(0));
    check("rst_ct_rdy", 128'(cipher_text_rdy_o), 128'(0));
    check("rst_ct", get_ct(), 128'(0));

    reset = 1'b0;
    aes_core_en = 1'b1;
    aes_encrypt_mode_en = 1'b1;
    tick();

    run_enc("appB", PT_B, 0, 1, 0, 0, 0, CT_B);
    check("appB_row0", 128'({cipher_text_o[0][0], cipher_text_o[0][1],
                             cipher_text_o[0][2], cipher_text_o[0][3]}), 128'(32'h3902dc19));
    tick();
    check("appB_hold", 128'(cipher_text_rdy_o), 128'(1));

    run_enc("appC", PT_C, 1, 1, 0, 0, 0, CT_C);
    run_enc("stretch", PT_B, 0, 3, 0, 0, 0, CT_B);

    run_enc("abort", PT_B, 0, 1, 1, 5, 0, CT_B);
    run_enc("restart", PT_B, 0, 1, 0, 0, 0, CT_B);

    aes_encrypt_mode_en = 1'b0;
    set_pt(PT_C);
    plain_text_vld_i = 1'b1;
    tick();
    plain_text_vld_i = 1'b0;
    check("mode0_req", 128'(key_req_o), 128'(0));
    check("mode0_rdy", 128'(core_rdy_o), 128'(1));
    tick();
    check("mode0_req2", 128'(key_req_o), 128'(0));
    check("mode0_ctrdy", 128'(cipher_text_rdy_o), 128'(1));
    aes_encrypt_mode_en = 1'b1;
    tick();

    run_enc("busy", PT_C, 1, 1, 0, 0, 1, CT_C);

    run_enc("midrst", PT_B, 0, 1, 2, 4, 0, CT_B);
    run_enc("after_rst", PT_C, 1, 1, 0, 0, 0, CT_C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_encryp_core.md
AES_ENCRYP_CORE -- requirements
Module: aes_encryp_core

Interface
REQ-001 SHALL have parameter NO_ROWS, default 4: state rows.
REQ-002 SHALL have parameter NO_COLS, default 4: state columns.
REQ-003 SHALL have parameters NO_SBOX_ROWS and NO_SBOX_COLS, default 16 each: S-box table dimensions.
REQ-004 SHALL have port aes_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port aes_core_en, input, 1: core enable; low aborts and idles.
REQ-007 SHALL have port aes_encrypt_mode_en, input, 1: encrypt mode select; starts are accepted only when high.
REQ-008 SHALL have port plain_text_i, input, [7:0] x [NO_ROWS][NO_COLS]: plaintext block, indexed [row][col].
REQ-009 SHALL have port plain_text_vld_i, input, 1: start request.
REQ-010 SHALL have port core_rdy_o, output, 1: idle, start can be accepted.
REQ-011 SHALL have port key_req_o, output, 1: round-key request.
REQ-012 SHALL have port key_sel_o, output, 4: requested round index, 0..10.
REQ-013 SHALL have port key_vld_i, input, 1: round key valid for key_sel_o.
REQ-014 SHALL have port cipher_key_i, input, [7:0] x [4][4]: round key, indexed [row][col].
REQ-015 SHALL have port cipher_text_o, output, [7:0] x [NO_ROWS][NO_COLS]: ciphertext, indexed [row][col].
REQ-016 SHALL have port cipher_text_rdy_o, output, 1: cipher_text_o valid.

Function
REQ-017 SHALL implement AES-128 encryption per FIPS-197, one round per accepted key, Nr=10.
REQ-018 SHALL accept a start when plain_text_vld_i, core_rdy_o, aes_core_en and aes_encrypt_mode_en are all high, and capture plain_text_i in that cycle.
REQ-019 SHALL run the FSM states IDLE -> REQ -> GAP -> REQ ... -> DONE -> IDLE.
- IDLE: core_rdy_o=1.
- REQ: key_req_o=1, held until key_vld_i=1.
- GAP: key_req_o=0 for one cycle after each accept.
- DONE: entered after round 10 is accepted.
REQ-020 SHALL, in the REQ cycle where key_vld_i=1, register the round result.
- Round 0: AddRoundKey only.
- Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
- Round 10: MixColumns omitted.
- key_sel_o then increments in GAP.
REQ-021 SHALL ignore key_vld_i while key_req_o is low; the responder deasserts key_vld_i when key_req_o is low.
REQ-022 SHALL, with key_vld_i asserted one cycle after each key_req_o rise, raise cipher_text_rdy_o in cycle start+33; stretched key latency extends this accordingly.
REQ-023 SHALL hold cipher_text_o and cipher_text_rdy_o high from DONE until the next accepted start, which clears cipher_text_rdy_o the following cycle.
REQ-024 SHALL return from DONE to IDLE in one cycle; core_rdy_o=1 in IDLE.
REQ-025 SHALL ignore plain_text_vld_i while busy, without corrupting the captured state.
REQ-026 SHALL, when aes_core_en falls mid-operation, go to IDLE next cycle, drop key_req_o, and leave cipher_text_rdy_o low.
REQ-027 SHALL refuse starts while aes_encrypt_mode_en=0; a mode change mid-operation does not abort.
REQ-028 SHALL keep key_sel_o in the range 0..10; there is no wrap past 10.

Reset
REQ-029 SHALL, on reset, force IDLE.
- core_rdy_o=1.
- key_req_o=0, key_sel_o=0.
- cipher_text_rdy_o=0.
- cipher_text_o all 8'h00.
- Applies mid-operation too, effective next cycle.

Structure
REQ-030 SHALL place in shared package aes_pkg:
- S-box constant.
- State typedef.
- NR=10.
- FSM enum.
- xtime function.
REQ-031 SHALL use one combinational sub-module, aes_enc_round: state, key and a final-round flag in; next state out.

Verification
REQ-032 SHALL cover FIPS-197 App. B.
- Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c; pt 3243f6a8 885a308d 313198a2 e0370734.
- Response: cipher_text_o row0 = 39,02,dc,19; ct 3925841d 02dc09fb dc118597 196a0b32 at cycle start+33.
REQ-033 SHALL cover FIPS-197 App. C.1.
- Stimulus: key 000102..0f; pt 00112233..ff.
- Response: ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
REQ-034 SHALL cover key latency stretched to 3 cycles per round.
- Response: same App. B ct; key_sel_o sequence 0..10 with a key_req_o low cycle between rounds.
REQ-035 SHALL cover aes_core_en dropped at round 5.
- Response: IDLE next cycle; key_req_o=0; cipher_text_rdy_o stays 0.
- A restart yields the correct ct.
REQ-036 SHALL cover aes_encrypt_mode_en=0 with a start pulse.
- Response: no key_req_o; core_rdy_o stays 1.
REQ-037 SHALL cover reset asserted mid-round and a start while busy.
- Response: all outputs take reset values next cycle; a busy start has no effect.
